// File: rtl/debug_ram_bridge.sv
// Host-side load/dump engine that drives the debug (second) port of the data or
// instruction BRAM and holds the CPU in reset while a command is in progress.
module debug_ram_bridge #(
    parameter int WORDS = 4096,
    parameter int CNTW  = 13
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic            cmd_sel,
    input  logic [31:0]     cmd_base,
    input  logic [CNTW-1:0] cmd_count,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [31:0]     wr_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [31:0]     rd_data,
    output logic [31:0]     rd_addr,
    output logic            done,
    output logic            cpu_hold,
    output logic [31:0]     Debug_DataRAM_A2,
    output logic [31:0]     Debug_DataRAM_WD2,
    output logic [3:0]      Debug_DataRAM_WE2,
    input  logic [31:0]     Debug_DataRAM_RD2,
    output logic [31:0]     Debug_InstRAM_A2,
    output logic [31:0]     Debug_InstRAM_WD2,
    output logic [3:0]      Debug_InstRAM_WE2,
    input  logic [31:0]     Debug_InstRAM_RD2
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_RD_OUT,
        ST_FIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_addr;
    logic [CNTW-1:0] r_remain;
    logic            r_sel;
    logic [31:0]     r_a2;
    logic [31:0]     r_wd2;
    logic [3:0]      r_we2;
    logic [31:0]     r_rd_data;
    logic [31:0]     r_rd_addr;

    logic [31:0]     w_base;
    logic [CNTW-1:0] w_count;
    logic            w_last;
    logic            w_active;
    logic [31:0]     w_rd2;

    assign w_base   = cmd_base & ~32'h3;
    assign w_count  = (cmd_count > CNTW'(WORDS)) ? CNTW'(WORDS) : cmd_count;
    assign w_last   = (r_remain == CNTW'(1));
    assign w_active = (r_state != ST_IDLE);
    assign w_rd2    = r_sel ? Debug_InstRAM_RD2 : Debug_DataRAM_RD2;

    // NOTE: every flop below uses non-blocking assignment so all registers
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        cpu_hold  = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                cpu_hold  = 1'b0;
                if (cmd_valid) begin
                    if (w_count == '0)  w_next = ST_FIN;
                    else if (cmd_op)    w_next = ST_RD_ISSUE;
                    else                w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid && w_last) w_next = ST_FIN;
            end
            ST_RD_ISSUE: w_next = ST_RD_CAP;
            ST_RD_CAP:   w_next = ST_RD_OUT;
            ST_RD_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) w_next = w_last ? ST_FIN : ST_RD_ISSUE;
            end
            ST_FIN: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_addr    <= '0;
            r_remain  <= '0;
            r_sel     <= 1'b0;
            r_a2      <= '0;
            r_wd2     <= '0;
            r_we2     <= '0;
            r_rd_data <= '0;
            r_rd_addr <= '0;
        end else begin
            r_we2 <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr   <= w_base;
                        r_remain <= w_count;
                        r_sel    <= cmd_sel;
                        r_a2     <= w_base;
                        r_wd2    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_valid) begin
                        r_a2     <= r_addr;
                        r_wd2    <= wr_data;
                        r_we2    <= 4'hF;
                        r_addr   <= r_addr + 32'd4;
                        r_remain <= r_remain - CNTW'(1);
                    end
                end
                ST_RD_CAP: begin
                    r_rd_data <= w_rd2;
                    r_rd_addr <= r_addr;
                end
                ST_RD_OUT: begin
                    // A2 steps with addr so the next RD_ISSUE presents the new word.
                    if (rd_ready) begin
                        r_addr   <= r_addr + 32'd4;
                        r_a2     <= r_addr + 32'd4;
                        r_remain <= r_remain - CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign rd_addr = r_rd_addr;

    assign Debug_DataRAM_A2  = (w_active && !r_sel) ? r_a2  : '0;
    assign Debug_DataRAM_WD2 = (w_active && !r_sel) ? r_wd2 : '0;
    assign Debug_DataRAM_WE2 = (w_active && !r_sel) ? r_we2 : '0;
    assign Debug_InstRAM_A2  = (w_active &&  r_sel) ? r_a2  : '0;
    assign Debug_InstRAM_WD2 = (w_active &&  r_sel) ? r_wd2 : '0;
    assign Debug_InstRAM_WE2 = (w_active &&  r_sel) ? r_we2 : '0;

endmodule

// File: tb/tb_debug_ram_bridge.sv
// Directed bench for debug_ram_bridge: two behavioural BRAMs on the debug ports,
// hand-computed expectations checked at negative clock edges.
module tb_debug_ram_bridge;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic        cmd_sel = 1'b0;
    logic [31:0] cmd_base = '0;
    logic [12:0] cmd_count = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [31:0] rd_addr;
    logic        done;
    logic        cpu_hold;
    logic [31:0] Debug_DataRAM_A2, Debug_DataRAM_WD2, Debug_DataRAM_RD2;
    logic [3:0]  Debug_DataRAM_WE2;
    logic [31:0] Debug_InstRAM_A2, Debug_InstRAM_WD2, Debug_InstRAM_RD2;
    logic [3:0]  Debug_InstRAM_WE2;

    int total = 0;
    int bad   = 0;

    logic [31:0] dmem [0:4095];
    logic [31:0] imem [0:4095];
    int          dwr_cnt = 0;
    int          iwr_cnt = 0;
    logic [31:0] last_dwa = '0;

    debug_ram_bridge #(.WORDS(4096), .CNTW(13)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
        .done(done), .cpu_hold(cpu_hold),
        .Debug_DataRAM_A2(Debug_DataRAM_A2), .Debug_DataRAM_WD2(Debug_DataRAM_WD2),
        .Debug_DataRAM_WE2(Debug_DataRAM_WE2), .Debug_DataRAM_RD2(Debug_DataRAM_RD2),
        .Debug_InstRAM_A2(Debug_InstRAM_A2), .Debug_InstRAM_WD2(Debug_InstRAM_WD2),
        .Debug_InstRAM_WE2(Debug_InstRAM_WE2), .Debug_InstRAM_RD2(Debug_InstRAM_RD2)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // Synchronous-read BRAM models; a write commits at the edge where WE2 is seen.
    always @(posedge CPU_CLK) begin
        if (Debug_DataRAM_WE2 == 4'hF) begin
            dmem[Debug_DataRAM_A2[13:2]] <= Debug_DataRAM_WD2;
            dwr_cnt  <= dwr_cnt + 1;
            last_dwa <= Debug_DataRAM_A2;
        end
        if (Debug_InstRAM_WE2 == 4'hF) begin
            imem[Debug_InstRAM_A2[13:2]] <= Debug_InstRAM_WD2;
            iwr_cnt <= iwr_cnt + 1;
        end
        Debug_DataRAM_RD2 <= dmem[Debug_DataRAM_A2[13:2]];
        Debug_InstRAM_RD2 <= imem[Debug_InstRAM_A2[13:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a negedge while idle; returns on the negedge right after the accept edge.
    task automatic issue(input logic op, input logic sel, input logic [31:0] base,
                         input logic [12:0] cnt);
        check("issue_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_base  = base;
        cmd_count = cnt;
        @(negedge CPU_CLK);
        cmd_valid = 1'b0;
    endtask

    logic [31:0] w4 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bit   [5:0]  pat = 6'b101001;

    initial begin
        int          n;
        int          nwords;
        int          d0;
        int          i0;
        logic [31:0] lastaddr;

        // ---- reset values ----
        #3 CPU_RST_N = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_addr", rd_addr, 32'd0);
        check("rst_ports", Debug_DataRAM_A2 | Debug_DataRAM_WD2 | 32'(Debug_DataRAM_WE2)
              | Debug_InstRAM_A2 | Debug_InstRAM_WD2 | 32'(Debug_InstRAM_WE2), 32'd0);
        repeat (2) @(negedge CPU_CLK);
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);

        // ---- load 4 words to data RAM at 0x100 ----
        d0 = dwr_cnt;
        i0 = iwr_cnt;
        issue(1'b0, 1'b0, 32'h100, 13'd4);
        check("ld_wr_ready", 32'(wr_ready), 32'd1);
        check("ld_cpu_hold", 32'(cpu_hold), 32'd1);
        check("ld_busy_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = w4[i];
            @(negedge CPU_CLK);
            check("ld_we", 32'(Debug_DataRAM_WE2), 32'hF);
            check("ld_a2", Debug_DataRAM_A2, 32'h100 + 32'(4 * i));
            check("ld_wd", Debug_DataRAM_WD2, w4[i]);
            check("ld_inst_we", 32'(Debug_InstRAM_WE2), 32'd0);
            check("ld_inst_a2", Debug_InstRAM_A2, 32'd0);
        end
        wr_valid = 1'b0;
        check("ld_done", 32'(done), 32'd1);
        @(negedge CPU_CLK);
        check("ld_done_end", 32'(done), 32'd0);
        check("ld_hold_end", 32'(cpu_hold), 32'd0);
        check("ld_we_idle", 32'(Debug_DataRAM_WE2), 32'd0);
        check("ld_dwr_cnt", 32'(dwr_cnt - d0), 32'd4);
        check("ld_iwr_cnt", 32'(iwr_cnt - i0), 32'd0);

        // ---- dump the same 4 words, rd_ready high ----
        rd_ready = 1'b1;
        issue(1'b1, 1'b0, 32'h100, 13'd4);
        for (int j = 0; j < 13; j++) begin
            if (j % 3 == 0 && j < 12)
                check("dmp_a2", Debug_DataRAM_A2, 32'h100 + 32'(4 * (j / 3)));
            check("dmp_valid", 32'(rd_valid), 32'(j % 3 == 2 && j < 12));
            if (j % 3 == 2 && j < 12) begin
                check("dmp_data", rd_data, w4[j / 3]);
                check("dmp_addr", rd_addr, 32'h100 + 32'(4 * (j / 3)));
            end
            check("dmp_done", 32'(done), 32'(j == 12));
            @(negedge CPU_CLK);
        end
        check("dmp_idle", 32'(cmd_ready), 32'd1);

        // ---- dump with a 5-cycle stall on word 2 ----
        rd_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h100, 13'd4);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!rd_valid && n < 8) begin
                @(negedge CPU_CLK);
                n++;
            end
            check("stl_valid", 32'(rd_valid), 32'd1);
            check("stl_data", rd_data, w4[i]);
            check("stl_addr", rd_addr, 32'h100 + 32'(4 * i));
            if (i == 1) begin
                repeat (5) begin
                    @(negedge CPU_CLK);
                    check("stl_hold_valid", 32'(rd_valid), 32'd1);
                    check("stl_hold_data", rd_data, w4[1]);
                    check("stl_hold_addr", rd_addr, 32'h104);
                    check("stl_hold_a2", Debug_DataRAM_A2, 32'h104);
                end
            end
            rd_ready = 1'b1;
            @(negedge CPU_CLK);
            rd_ready = 1'b0;
            check("stl_drop", 32'(rd_valid), 32'd0);
        end
        check("stl_done", 32'(done), 32'd1);
        @(negedge CPU_CLK);

        // ---- load to inst RAM, unaligned base, wr_valid gaps ----
        d0 = dwr_cnt;
        issue(1'b0, 1'b1, 32'h203, 13'd3);
        n = 0;
        for (int j = 0; j < 6; j++) begin
            wr_valid = pat[j];
            wr_data  = 32'hE0 + 32'(n);
            @(negedge CPU_CLK);
            if (pat[j]) begin
                check("gap_we", 32'(Debug_InstRAM_WE2), 32'hF);
                check("gap_a2", Debug_InstRAM_A2, 32'h200 + 32'(4 * n));
                check("gap_wd", Debug_InstRAM_WD2, 32'hE0 + 32'(n));
                n++;
            end else begin
                check("gap_we_idle", 32'(Debug_InstRAM_WE2), 32'd0);
            end
            check("gap_data_we", 32'(Debug_DataRAM_WE2), 32'd0);
        end
        wr_valid = 1'b0;
        check("gap_done", 32'(done), 32'd1);
        @(negedge CPU_CLK);
        check("gap_mem0", imem[12'h080], 32'hE0);
        check("gap_mem2", imem[12'h082], 32'hE2);
        check("gap_dwr", 32'(dwr_cnt - d0), 32'd0);

        // ---- count 0: no access, done after one cycle ----
        d0 = dwr_cnt;
        i0 = iwr_cnt;
        issue(1'b0, 1'b0, 32'h300, 13'd0);
        check("c0_done", 32'(done), 32'd1);
        check("c0_wr_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        @(negedge CPU_CLK);
        wr_valid = 1'b0;
        check("c0_done_end", 32'(done), 32'd0);
        check("c0_idle", 32'(cmd_ready), 32'd1);
        @(negedge CPU_CLK);
        check("c0_no_write", 32'(dwr_cnt - d0 + iwr_cnt - i0), 32'd0);

        // ---- count 5000 on inst RAM dump: clipped to 4096 words ----
        rd_ready = 1'b1;
        issue(1'b1, 1'b1, 32'h0, 13'd5000);
        nwords   = 0;
        lastaddr = '0;
        n        = 0;
        while (!done && n < 14000) begin
            if (rd_valid) begin
                nwords++;
                lastaddr = rd_addr;
            end
            check("big_data_port", Debug_DataRAM_A2, 32'd0);
            @(negedge CPU_CLK);
            n++;
        end
        rd_ready = 1'b0;
        check("big_done", 32'(done), 32'd1);
        check("big_words", 32'(nwords), 32'd4096);
        check("big_last_addr", lastaddr, 32'h3FFC);
        @(negedge CPU_CLK);

        // ---- reset during word 3 of a 10-word load ----
        d0 = dwr_cnt;
        issue(1'b0, 1'b0, 32'h400, 13'd10);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hC0 + 32'(i);
            @(negedge CPU_CLK);
        end
        check("rmc_we_pre", 32'(Debug_DataRAM_WE2), 32'hF);
        check("rmc_a2_pre", Debug_DataRAM_A2, 32'h408);
        CPU_RST_N = 1'b0;
        wr_valid  = 1'b0;
        #1;
        check("rmc_we", 32'(Debug_DataRAM_WE2), 32'd0);
        check("rmc_hold", 32'(cpu_hold), 32'd0);
        check("rmc_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge CPU_CLK);
        check("rmc_writes", 32'(dwr_cnt - d0), 32'd2);
        check("rmc_last_addr", last_dwa, 32'h404);
        check("rmc_mem1", dmem[12'h101], 32'hC1);
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);
        issue(1'b0, 1'b0, 32'h500, 13'd1);
        check("rmc_new_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        @(negedge CPU_CLK);
        wr_valid = 1'b0;
        check("rmc_new_a2", Debug_DataRAM_A2, 32'h500);
        check("rmc_new_done", 32'(done), 32'd1);
        @(negedge CPU_CLK);
        check("rmc_new_mem", dmem[12'h140], 32'hDEADBEEF);
        check("rmc_new_idle", 32'(cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
